aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 148 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES core: launches key expansion, then steps NR+1 round keys.
// Define AES_KEY_CACHE_EN to skip re-expansion while the expanded schedule is still valid.
module aes_round_ctrl #(
  parameter int unsigned NR          = 14,
  parameter int unsigned KEY_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt,
  input  logic       key_new,
  output logic       ek_ready,
  input  logic       ek_valid,
  output logic [3:0] rk_idx,
  output logic       round_en,
  output logic       round_first,
  output logic       round_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned      TmoW    = $clog2(KEY_TIMEOUT + 1);
  localparam logic [3:0]       LastIdx = 4'(NR);
  localparam logic [TmoW-1:0]  TmoMax  = TmoW'(KEY_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StExpand, StWaitKey, StRound, StDone} state_e;

  state_e          state_q, state_d;
  logic            dec_q, dec_d;
  logic            err_q, err_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            need_exp;
  logic            rnd_first, rnd_last;

`ifdef AES_KEY_CACHE_EN
  logic keys_ok_q, keys_ok_d;
  assign need_exp = key_new | ~keys_ok_q;
`else
  logic unused_key_new;
  assign unused_key_new = key_new;
  assign need_exp       = 1'b1;
`endif

  // First/last are relative to the direction latched at acceptance.
  assign rnd_first = dec_q ? (rnd_q == LastIdx) : (rnd_q == 4'd0);
  assign rnd_last  = dec_q ? (rnd_q == 4'd0)    : (rnd_q == LastIdx);

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    err_d   = err_q;
    rnd_d   = rnd_q;
    tmo_d   = tmo_q;
`ifdef AES_KEY_CACHE_EN
    keys_ok_d = keys_ok_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dec_d = decrypt;
          err_d = 1'b0;
          if (need_exp) begin
            state_d = StExpand;
          end else begin
            state_d = StRound;
            rnd_d   = decrypt ? LastIdx : 4'd0;
          end
        end
      end
      StExpand: begin
        tmo_d   = '0;
        state_d = StWaitKey;
      end
      StWaitKey: begin
        if (ek_valid) begin
          state_d = StRound;
          rnd_d   = dec_q ? LastIdx : 4'd0;
`ifdef AES_KEY_CACHE_EN
          keys_ok_d = 1'b1;
`endif
        end else if (tmo_q == TmoMax) begin
          state_d = StDone;
          err_d   = 1'b1;
`ifdef AES_KEY_CACHE_EN
          keys_ok_d = 1'b0;
`endif
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StRound: begin
        // Stepping stops at the terminal index, so the counter never leaves 0..NR.
        if (rnd_last) begin
          state_d = StDone;
          rnd_d   = 4'd0;
        end else if (dec_q) begin
          rnd_d = rnd_q - 1'b1;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
      rnd_q   <= 4'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      rnd_q   <= rnd_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef AES_KEY_CACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_ok_q <= 1'b0;
    end else begin
      keys_ok_q <= keys_ok_d;
    end
  end
`endif

  assign ek_ready    = (state_q == StExpand);
  assign round_en    = (state_q == StRound);
  assign round_first = round_en & rnd_first;
  assign round_last  = round_en & rnd_last;
  assign rk_idx      = round_en ? rnd_q : 4'd0;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign err         = done & err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: expected round-key steps and done/err are queued at start.
module tb_aes_round_ctrl;

  localparam int unsigned NR          = 14;
  localparam int unsigned KEY_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst, start, decrypt, key_new;
  logic       ek_valid = 1'b0;
  logic       ek_ready, round_en, round_first, round_last, busy, done, err;
  logic [3:0] rk_idx;

  aes_round_ctrl #(.NR(NR), .KEY_TIMEOUT(KEY_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .decrypt    (decrypt),
    .key_new    (key_new),
    .ek_ready   (ek_ready),
    .ek_valid   (ek_valid),
    .rk_idx     (rk_idx),
    .round_en   (round_en),
    .round_first(round_first),
    .round_last (round_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic       first;
    logic       last;
  } rk_t;

  rk_t  rk_q[$];
  logic done_q[$];
  rk_t  exp_rk;
  logic exp_err;

  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0;
  int ek_pulses = 0, rnd_cnt = 0, done_cnt = 0;
  int last_ek_cyc = 0, first_rnd_cyc = 0, last_done_cyc = 0;
  bit mon_en = 0, bench_keys_ok = 0;
  int kx_delay = 4, kx_cnt = 0;
  bit kx_armed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Key expander model plus output monitor, both on the falling edge.
  always @(negedge clk) begin
    if (ek_ready === 1'b1) begin
      kx_cnt   = kx_delay;
      kx_armed = 1;
    end else if (kx_armed && kx_cnt > 0) begin
      kx_cnt--;
    end
    ek_valid = kx_armed && (kx_cnt == 0);
    if (mon_en) begin
      checks++;
      if ((round_en !== 1'b1 && {rk_idx, round_first, round_last} !== 6'd0) ||
          (done !== 1'b1 && err !== 1'b0)) begin
        errors++;
        $display("FAIL idle_gating: round_en=%b rk_idx=%0d first=%b last=%b done=%b err=%b, required zeros",
                 round_en, rk_idx, round_first, round_last, done, err);
      end
      if (ek_ready === 1'b1) begin
        ek_pulses++;
        last_ek_cyc = cyc;
      end
      if (round_en === 1'b1) begin
        rnd_cnt++;
        if (round_first === 1'b1) first_rnd_cyc = cyc;
        checks++;
        if (rk_q.size() == 0) begin
          errors++;
          $display("FAIL round_step: round_en with rk_idx=%0d, required no round", rk_idx);
        end else begin
          exp_rk = rk_q.pop_front();
          if ({rk_idx, round_first, round_last} !== {exp_rk.idx, exp_rk.first, exp_rk.last}) begin
            errors++;
            $display("FAIL round_step: idx=%0d first=%b last=%b, required idx=%0d first=%b last=%b",
                     rk_idx, round_first, round_last, exp_rk.idx, exp_rk.first, exp_rk.last);
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_pulse: done with err=%b, required no done", err);
        end else begin
          exp_err = done_q.pop_front();
          if (err !== exp_err) begin
            errors++;
            $display("FAIL done_err: err=%b, required %b", err, exp_err);
          end
        end
      end
    end
  end

  function automatic bit exp_needed(input logic kn);
`ifdef AES_KEY_CACHE_EN
    return kn || !bench_keys_ok;
`else
    return (kn === kn);
`endif
  endfunction

  task automatic step_to(input int rel);
    while (cyc - start_cyc < rel) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drive a one-cycle start and queue what the accepted operation must produce.
  task automatic issue_start(input logic dec, input logic kn, input bit exp_to);
    start     = 1'b1;
    decrypt   = dec;
    key_new   = kn;
    start_cyc = cyc;
    if (!exp_to) begin
      for (int i = 0; i <= int'(NR); i++) begin
        rk_t r;
        r.idx   = dec ? 4'(int'(NR) - i) : 4'(i);
        r.first = (i == 0);
        r.last  = (i == int'(NR));
        rk_q.push_back(r);
      end
    end
    done_q.push_back(exp_to);
    bench_keys_ok = !exp_to;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n0 = done_cnt;
    int i  = 0;
    while (done_cnt == n0 && i < budget) begin
      @(posedge clk);
      #2;
      i++;
    end
    checks++;
    if (done_cnt == n0) begin
      errors++;
      $display("FAIL %s: no done within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; decrypt = 1'b1; key_new = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    mon_en = 1;
    checks++;
    if ({ek_ready, rk_idx, round_en, round_first, round_last, busy, done, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {ek_ready, rk_idx, round_en, round_first, round_last, busy, done, err});
    end
    rst = 1'b0; start = 1'b0; decrypt = 1'b0; key_new = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || ek_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_with_rst: busy=%b ek_ready=%b, required 0 0", busy, ek_ready);
    end
    bench_keys_ok = 0;
  endtask

  task automatic test_encrypt();
    int ek0 = ek_pulses;
    kx_delay = 4;
    issue_start(1'b0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL enc_busy: busy=%b, required 1", busy);
    end
    wait_done(200, "enc_done");
    checks++;
    if (ek_pulses - ek0 != 1) begin
      errors++;
      $display("FAIL enc_ek_count: %0d pulses, required 1", ek_pulses - ek0);
    end
    checks++;
    if (last_ek_cyc - start_cyc != 1) begin
      errors++;
      $display("FAIL enc_ek_time: cycle +%0d, required +1", last_ek_cyc - start_cyc);
    end
    checks++;
    if (first_rnd_cyc - start_cyc != 6) begin
      errors++;
      $display("FAIL enc_first_round: cycle +%0d, required +6", first_rnd_cyc - start_cyc);
    end
    checks++;
    if (last_done_cyc - start_cyc != 6 + int'(NR) + 1) begin
      errors++;
      $display("FAIL enc_done_time: cycle +%0d, required +%0d", last_done_cyc - start_cyc,
               6 + int'(NR) + 1);
    end
  endtask

  task automatic test_cached_decrypt();
    int ek0 = ek_pulses;
    bit e   = exp_needed(1'b0);
    int first_rel = e ? 5 : 1;
    kx_delay = 3;
    issue_start(1'b1, 1'b0, 1'b0);
    wait_done(200, "dec_done");
    checks++;
    if (ek_pulses - ek0 != (e ? 1 : 0)) begin
      errors++;
      $display("FAIL dec_ek_count: %0d pulses, required %0d", ek_pulses - ek0, e ? 1 : 0);
    end
    checks++;
    if (first_rnd_cyc - start_cyc != first_rel) begin
      errors++;
      $display("FAIL dec_first_round: cycle +%0d, required +%0d", first_rnd_cyc - start_cyc,
               first_rel);
    end
    checks++;
    if (last_done_cyc - start_cyc != first_rel + int'(NR) + 1) begin
      errors++;
      $display("FAIL dec_done_time: cycle +%0d, required +%0d", last_done_cyc - start_cyc,
               first_rel + int'(NR) + 1);
    end
  endtask

  task automatic test_timeout();
    int ek0 = ek_pulses;
    int rn0 = rnd_cnt;
    kx_delay = 100000;
    issue_start(1'b0, 1'b1, 1'b1);
    wait_done(KEY_TIMEOUT + 20, "tmo_done");
    checks++;
    if (last_done_cyc - start_cyc != 2 + int'(KEY_TIMEOUT)) begin
      errors++;
      $display("FAIL tmo_done_time: cycle +%0d, required +%0d", last_done_cyc - start_cyc,
               2 + int'(KEY_TIMEOUT));
    end
    checks++;
    if (rnd_cnt != rn0) begin
      errors++;
      $display("FAIL tmo_no_round: %0d round cycles, required 0", rnd_cnt - rn0);
    end
    kx_delay = 2;
    ek0 = ek_pulses;
    issue_start(1'b0, 1'b0, 1'b0);
    wait_done(200, "tmo_reexp_done");
    checks++;
    if (ek_pulses - ek0 != 1) begin
      errors++;
      $display("FAIL tmo_reexpand: %0d pulses, required 1", ek_pulses - ek0);
    end
    checks++;
    if (last_done_cyc - start_cyc != 4 + int'(NR) + 1) begin
      errors++;
      $display("FAIL tmo_reexp_time: cycle +%0d, required +%0d", last_done_cyc - start_cyc,
               4 + int'(NR) + 1);
    end
  endtask

  task automatic test_busy_start();
    int ek0 = ek_pulses;
    int dn0 = done_cnt;
    kx_delay = 6;
    issue_start(1'b0, 1'b1, 1'b0);
    step_to(3);
    start = 1'b1; decrypt = 1'b1; key_new = 1'b1;
    step_to(4);
    start = 1'b0; decrypt = 1'b0; key_new = 1'b0;
    step_to(14);
    start = 1'b1; decrypt = 1'b1; key_new = 1'b1;
    step_to(15);
    start = 1'b0; decrypt = 1'b0; key_new = 1'b0;
    wait_done(100, "busy_done");
    step_to(45);
    checks++;
    if (done_cnt - dn0 != 1) begin
      errors++;
      $display("FAIL busy_done_count: %0d dones, required 1", done_cnt - dn0);
    end
    checks++;
    if (ek_pulses - ek0 != 1) begin
      errors++;
      $display("FAIL busy_ek_count: %0d pulses, required 1", ek_pulses - ek0);
    end
    checks++;
    if (last_done_cyc - start_cyc != 8 + int'(NR) + 1) begin
      errors++;
      $display("FAIL busy_done_time: cycle +%0d, required +%0d", last_done_cyc - start_cyc,
               8 + int'(NR) + 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_round();
    int ek0;
    int i = 0;
    kx_delay = 2;
    issue_start(1'b0, 1'b0, 1'b0);
    while (!(round_en === 1'b1 && rk_idx === 4'd7) && i < 100) begin
      @(posedge clk);
      #2;
      i++;
    end
    checks++;
    if (i >= 100) begin
      errors++;
      $display("FAIL rst_find_idx7: rk_idx=7 not seen in 100 cycles, required it");
    end
    rst = 1'b1;
    @(posedge clk);
    #2;
    rk_q.delete();
    done_q.delete();
    bench_keys_ok = 0;
    checks++;
    if ({ek_ready, rk_idx, round_en, round_first, round_last, busy, done, err} !== 11'd0) begin
      errors++;
      $display("FAIL rst_mid_round: got %b, required all zero",
               {ek_ready, rk_idx, round_en, round_first, round_last, busy, done, err});
    end
    rst = 1'b0;
    @(posedge clk);
    #2;
    ek0 = ek_pulses;
    issue_start(1'b0, 1'b0, 1'b0);
    wait_done(200, "rst_after_done");
    checks++;
    if (ek_pulses - ek0 != 1) begin
      errors++;
      $display("FAIL rst_reexpand: %0d pulses, required 1", ek_pulses - ek0);
    end
    checks++;
    if (last_done_cyc - start_cyc != 4 + int'(NR) + 1) begin
      errors++;
      $display("FAIL rst_done_time: cycle +%0d, required +%0d", last_done_cyc - start_cyc,
               4 + int'(NR) + 1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_new = 1'b0;
    test_reset();
    test_encrypt();
    test_cached_decrypt();
    test_timeout();
    test_busy_start();
    test_reset_mid_round();
    repeat (3) @(posedge clk);
    checks++;
    if (rk_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d rounds and %0d dones outstanding, required 0",
               rk_q.size(), done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
